timer_sched: RTL and testbench
==============================

// Module: timer_sched
// PURPOSE
//  Multi-channel timeout scheduler driven by the prescaled tick of an upstream timer instance.
//  Each channel is loaded with a tick count in one-shot or periodic mode and counts down on tick_in.
//  Expiries are queued per channel and reported one at a time on a valid/ready event port, round-robin.
//  Sits between the tick generator and control logic (FX2/comm FSMs) that needs several watchdogs/timeouts.
// PARAMETERS
//  NUM_CHAN     4   number of channels (2..16); CHAN_WIDTH = clog2(NUM_CHAN), min 1
//  COUNT_WIDTH  16  width of per-channel load/remaining count
// PORTS
//  clk_in          in   1            single clock; all state on rising edge
//  reset_in        in   1            asynchronous, active-low reset
//  tick_in         in   1            one-cycle strobe from upstream timer; one "tick" per pulse
//  cfg_valid_in    in   1            config command strobe; always accepted (no ready)
//  cfg_chan_in     in   CHAN_WIDTH   target channel; values >= NUM_CHAN ignored
//  cfg_cmd_in      in   2            0 NOP, 1 LOAD_ONESHOT, 2 LOAD_PERIODIC, 3 STOP
//  cfg_count_in    in   COUNT_WIDTH  load value N (ticks until expiry)
//  evt_valid_out   out  1            expiry event available
//  evt_chan_out    out  CHAN_WIDTH   channel that expired
//  evt_overrun_out out  1            channel expired again while its previous event was still pending
//  evt_ready_in    in   1            consumer accepts event when valid && ready
//  busy_out        out  NUM_CHAN     bit i = channel i RUNNING
// BEHAVIOUR
//  Reset (async assert, sync deassert inside): all channels IDLE, counts 0, pending/overrun 0,
//   evt_valid_out=0, evt_chan_out=0, evt_overrun_out=0, busy_out=0, RR pointer=0.
//  Channel states: IDLE -> RUN (LOAD_*); RUN -> IDLE (STOP, or one-shot expiry); RUN -> RUN (periodic expiry, reload).
//  Load: remaining <= (N==0 ? 1 : N); reload register <= same. Takes effect the cycle after cfg_valid_in.
//  Count: in RUN, each tick_in decrements remaining; tick that moves remaining 1->0 = expiry.
//   Expiry sets pending[i]; if pending[i] already set, sets overrun[i] instead (no second event queued).
//   Periodic: remaining <= reload on the expiry cycle, so period is exactly N ticks, no drift.
//  Simultaneous cfg and tick on same channel: cfg wins, tick ignored for that channel that cycle.
//  LOAD on a RUN channel restarts it; LOAD/STOP clear pending[i] and overrun[i] not yet in output reg.
//  Output register: one-entry; loads when empty or accepted this cycle (valid&&ready).
//   Arbiter picks first pending channel at or after RR pointer (wrapping); pointer <= winner+1 mod NUM_CHAN.
//   Loading clears pending/overrun of the winner in the same cycle; an expiry of that channel in that cycle
//   sets pending again (not overrun). Back-to-back events at one per cycle when ready held high.
//  evt_* stable while evt_valid_out && !evt_ready_in; STOP/LOAD never retracts an event already presented.
//  tick_in with all channels IDLE: no effect. Expiry latency: event visible cycle after the expiring tick
//   if output reg is free (registered; no comb path tick_in -> evt_valid_out).
// CONFIGURATION
//  TIMER_SCHED_READBACK_EN defined: adds ports rd_chan_in (in, CHAN_WIDTH) and rd_count_out
//   (out, COUNT_WIDTH); rd_count_out = registered remaining count of rd_chan_in, 1-cycle latency,
//   0 for IDLE or out-of-range channel, reset 0.
//  Not defined: ports absent; no readback mux logic synthesised. All other behaviour identical.
// STRUCTURE
//  timer_sched_defs.vh (shared include): CMD_NOP/CMD_LOAD_ONESHOT/CMD_LOAD_PERIODIC/CMD_STOP
//   localparams, channel state encodings, clog2 function.
//  Sub-module timer_sched_chan: one channel (state, remaining, reload, pending, overrun), generate-replicated
//   NUM_CHAN times; top holds cfg decode, RR arbiter, output register, optional readback mux.
// TESTING
//  Reset mid-count: LOAD_ONESHOT ch0 N=5, 3 ticks, assert reset_in=0 -> busy_out=0, evt_valid_out=0 at once.
//  One-shot: LOAD_ONESHOT ch1 N=3, ready=1, 3 ticks -> single event chan=1 overrun=0 after 3rd tick; busy[1]=0.
//  Periodic+overrun: LOAD_PERIODIC ch2 N=2, ready=0, 6 ticks -> one event chan=2 overrun=1; ready=1 then
//   events every 2 ticks, overrun=0; busy[2] stays 1.
//  Round-robin: ch0..3 all N=1, one tick, ready=0 then ready=1 -> events 0,1,2,3 on consecutive cycles;
//   reload all, tick again -> order resumes from pointer (0,1,2,3).
//  Collision: cfg STOP ch3 same cycle its expiring tick -> no event, busy[3]=0; LOAD N=0 -> expires after 1 tick.
//  Backpressure: event held with ready=0 for 10 cycles -> evt_chan_out/evt_overrun_out unchanged; readback
//   (TIMER_SCHED_READBACK_EN) of running ch N=10 after 4 ticks -> rd_count_out=6.

Source files
------------

// File: rtl/timer_sched_pkg.sv
// Shared command codes, channel state encodings and width helper for timer_sched.
// Optional readback port is enabled by TIMER_SCHED_READBACK_EN.
package timer_sched_pkg;

  localparam logic [1:0] CMD_NOP           = 2'd0;
  localparam logic [1:0] CMD_LOAD_ONESHOT  = 2'd1;
  localparam logic [1:0] CMD_LOAD_PERIODIC = 2'd2;
  localparam logic [1:0] CMD_STOP          = 2'd3;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  // ceil(log2(n)) with a floor of 1 bit
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/timer_sched_chan.sv
// One timeout channel: countdown, periodic reload, pending/overrun event flags.
// TIMER_SCHED_READBACK_EN exposes the remaining count.
module timer_sched_chan
  import timer_sched_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk_in,
  input  logic                   reset_in,
  input  logic                   tick_in,
  input  logic                   load_in,
  input  logic                   periodic_in,
  input  logic                   stop_in,
  input  logic [COUNT_WIDTH-1:0] count_in,
  input  logic                   take_in,
  output logic                   req_c,
  output logic                   overrun_out,
`ifdef TIMER_SCHED_READBACK_EN
  output logic [COUNT_WIDTH-1:0] count_out,
`endif
  output logic                   busy_out
);

  logic                   state, state_n;
  logic                   periodic, periodic_n;
  logic [COUNT_WIDTH-1:0] remaining, remaining_n;
  logic [COUNT_WIDTH-1:0] reload, reload_n;
  logic                   pending, pending_n;
  logic                   overrun, overrun_n;
  logic                   expire_c;

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state     <= ST_IDLE;
      periodic  <= 1'b0;
      remaining <= '0;
      reload    <= '0;
      pending   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      periodic  <= periodic_n;
      remaining <= remaining_n;
      reload    <= reload_n;
      pending   <= pending_n;
      overrun   <= overrun_n;
    end
  end

  // Config beats a same-cycle tick; a taken event can be re-armed by an expiry in the same cycle.
  always_comb begin
    state_n     = state;
    periodic_n  = periodic;
    remaining_n = remaining;
    reload_n    = reload;
    pending_n   = pending;
    overrun_n   = overrun;
    expire_c    = (state == ST_RUN) && tick_in && !load_in && !stop_in &&
                  (remaining == COUNT_WIDTH'(1));

    if (load_in) begin
      state_n     = ST_RUN;
      periodic_n  = periodic_in;
      remaining_n = (count_in == '0) ? COUNT_WIDTH'(1) : count_in;
      reload_n    = (count_in == '0) ? COUNT_WIDTH'(1) : count_in;
      pending_n   = 1'b0;
      overrun_n   = 1'b0;
    end else if (stop_in) begin
      state_n     = ST_IDLE;
      remaining_n = '0;
      pending_n   = 1'b0;
      overrun_n   = 1'b0;
    end else begin
      if (state == ST_RUN && tick_in) begin
        if (expire_c) begin
          if (periodic) begin
            remaining_n = reload;
          end else begin
            state_n     = ST_IDLE;
            remaining_n = '0;
          end
        end else begin
          remaining_n = remaining - COUNT_WIDTH'(1);
        end
      end
      if (take_in) begin
        pending_n = pending & expire_c;
        overrun_n = 1'b0;
      end else if (expire_c) begin
        if (pending) overrun_n = 1'b1;
        else         pending_n = 1'b1;
      end
    end
  end

  assign req_c       = pending | expire_c;
  assign overrun_out = overrun;
  assign busy_out    = (state == ST_RUN);
`ifdef TIMER_SCHED_READBACK_EN
  assign count_out   = remaining;
`endif

endmodule

// File: rtl/timer_sched.sv
// Multi-channel tick-driven timeout scheduler with round-robin expiry event port.
// TIMER_SCHED_READBACK_EN adds rd_chan_in/rd_count_out remaining-count readback.
module timer_sched
  import timer_sched_pkg::*;
#(
  parameter  int unsigned NUM_CHAN    = 4,
  parameter  int unsigned COUNT_WIDTH = 16,
  localparam int unsigned CHAN_WIDTH  = clog2_min1(NUM_CHAN)
) (
  input  logic                   clk_in,
  input  logic                   reset_in,
  input  logic                   tick_in,
  input  logic                   cfg_valid_in,
  input  logic [CHAN_WIDTH-1:0]  cfg_chan_in,
  input  logic [1:0]             cfg_cmd_in,
  input  logic [COUNT_WIDTH-1:0] cfg_count_in,
  output logic                   evt_valid_out,
  output logic [CHAN_WIDTH-1:0]  evt_chan_out,
  output logic                   evt_overrun_out,
  input  logic                   evt_ready_in,
`ifdef TIMER_SCHED_READBACK_EN
  input  logic [CHAN_WIDTH-1:0]  rd_chan_in,
  output logic [COUNT_WIDTH-1:0] rd_count_out,
`endif
  output logic [NUM_CHAN-1:0]    busy_out
);

  logic [NUM_CHAN-1:0]   load_c, periodic_c, stop_c, take_c, req_c, ovr_c;
  logic [CHAN_WIDTH-1:0] rr_ptr;
  logic                  load_en_c, found_c, win_ovr_c;
  logic [CHAN_WIDTH-1:0] win_c, ptr_nxt_c;
`ifdef TIMER_SCHED_READBACK_EN
  logic [COUNT_WIDTH-1:0] count_c [NUM_CHAN];
`endif

  // Per-channel command decode
  always_comb begin
    load_c     = '0;
    periodic_c = '0;
    stop_c     = '0;
    for (int i = 0; i < int'(NUM_CHAN); i++) begin
      if (cfg_valid_in && (cfg_chan_in == CHAN_WIDTH'(i))) begin
        load_c[i]     = (cfg_cmd_in == CMD_LOAD_ONESHOT) || (cfg_cmd_in == CMD_LOAD_PERIODIC);
        periodic_c[i] = (cfg_cmd_in == CMD_LOAD_PERIODIC);
        stop_c[i]     = (cfg_cmd_in == CMD_STOP);
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_CHAN); g++) begin : g_chan
    timer_sched_chan #(.COUNT_WIDTH(COUNT_WIDTH)) u_chan (
      .clk_in      (clk_in),
      .reset_in    (reset_in),
      .tick_in     (tick_in),
      .load_in     (load_c[g]),
      .periodic_in (periodic_c[g]),
      .stop_in     (stop_c[g]),
      .count_in    (cfg_count_in),
      .take_in     (take_c[g]),
      .req_c       (req_c[g]),
      .overrun_out (ovr_c[g]),
`ifdef TIMER_SCHED_READBACK_EN
      .count_out   (count_c[g]),
`endif
      .busy_out    (busy_out[g])
    );
  end

  // Round-robin: first requester at or after rr_ptr, wrapping
  always_comb begin
    int idx;
    found_c   = 1'b0;
    win_c     = '0;
    win_ovr_c = 1'b0;
    ptr_nxt_c = rr_ptr;
    idx       = 0;
    for (int k = 0; k < int'(NUM_CHAN); k++) begin
      idx = (int'(rr_ptr) + k) % int'(NUM_CHAN);
      if (!found_c && req_c[idx]) begin
        found_c   = 1'b1;
        win_c     = CHAN_WIDTH'(idx);
        win_ovr_c = ovr_c[idx];
        ptr_nxt_c = CHAN_WIDTH'((idx + 1) % int'(NUM_CHAN));
      end
    end
  end

  assign load_en_c = !evt_valid_out || evt_ready_in;

  always_comb begin
    take_c = '0;
    for (int i = 0; i < int'(NUM_CHAN); i++) begin
      take_c[i] = load_en_c && found_c && (win_c == CHAN_WIDTH'(i));
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      evt_valid_out   <= 1'b0;
      evt_chan_out    <= '0;
      evt_overrun_out <= 1'b0;
      rr_ptr          <= '0;
    end else if (load_en_c) begin
      evt_valid_out <= found_c;
      if (found_c) begin
        evt_chan_out    <= win_c;
        evt_overrun_out <= win_ovr_c;
        rr_ptr          <= ptr_nxt_c;
      end
    end
  end

`ifdef TIMER_SCHED_READBACK_EN
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      rd_count_out <= '0;
    end else if ((32'(rd_chan_in) < NUM_CHAN) && busy_out[rd_chan_in]) begin
      rd_count_out <= count_c[rd_chan_in];
    end else begin
      rd_count_out <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_timer_sched.sv
// Directed self-checking bench for timer_sched (readback checks when TIMER_SCHED_READBACK_EN).
module tb_timer_sched;
  import timer_sched_pkg::*;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        tick_in;
  logic        cfg_valid_in;
  logic [1:0]  cfg_chan_in;
  logic [1:0]  cfg_cmd_in;
  logic [15:0] cfg_count_in;
  logic        evt_valid_out;
  logic [1:0]  evt_chan_out;
  logic        evt_overrun_out;
  logic        evt_ready_in;
  logic [3:0]  busy_out;
`ifdef TIMER_SCHED_READBACK_EN
  logic [1:0]  rd_chan_in;
  logic [15:0] rd_count_out;
`endif

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk_in = ~clk_in;

  timer_sched #(.NUM_CHAN(4), .COUNT_WIDTH(16)) dut (
    .clk_in          (clk_in),
    .reset_in        (reset_in),
    .tick_in         (tick_in),
    .cfg_valid_in    (cfg_valid_in),
    .cfg_chan_in     (cfg_chan_in),
    .cfg_cmd_in      (cfg_cmd_in),
    .cfg_count_in    (cfg_count_in),
    .evt_valid_out   (evt_valid_out),
    .evt_chan_out    (evt_chan_out),
    .evt_overrun_out (evt_overrun_out),
    .evt_ready_in    (evt_ready_in),
`ifdef TIMER_SCHED_READBACK_EN
    .rd_chan_in      (rd_chan_in),
    .rd_count_out    (rd_count_out),
`endif
    .busy_out        (busy_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [1:0] cmd, input logic [15:0] n);
    cfg_valid_in = 1'b1;
    cfg_chan_in  = ch;
    cfg_cmd_in   = cmd;
    cfg_count_in = n;
    step();
    cfg_valid_in = 1'b0;
    cfg_cmd_in   = CMD_NOP;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick_in = 1'b1;
      step();
      tick_in = 1'b0;
    end
  endtask

  task automatic check_evt(input string tag, input logic v, input logic [1:0] ch, input logic ov);
    check({tag, ".valid"}, 32'(evt_valid_out), 32'(v));
    if (v) begin
      check({tag, ".chan"}, 32'(evt_chan_out), 32'(ch));
      check({tag, ".ovr"}, 32'(evt_overrun_out), 32'(ov));
    end
  endtask

  initial begin
    reset_in     = 1'b0;
    tick_in      = 1'b0;
    cfg_valid_in = 1'b0;
    cfg_chan_in  = '0;
    cfg_cmd_in   = CMD_NOP;
    cfg_count_in = '0;
    evt_ready_in = 1'b0;
`ifdef TIMER_SCHED_READBACK_EN
    rd_chan_in   = '0;
`endif
    #12;
    check("rst.busy", 32'(busy_out), 32'h0);
    check("rst.valid", 32'(evt_valid_out), 32'h0);
    check("rst.chan", 32'(evt_chan_out), 32'h0);
    check("rst.ovr", 32'(evt_overrun_out), 32'h0);
`ifdef TIMER_SCHED_READBACK_EN
    check("rst.rd", 32'(rd_count_out), 32'h0);
`endif
    reset_in = 1'b1;
    step();

    // reset in the middle of a countdown
    cfg(2'd0, CMD_LOAD_ONESHOT, 16'd5);
    check("midrst.busy_pre", 32'(busy_out), 32'h1);
    tick_n(3);
    check_evt("midrst.pre", 1'b0, 2'd0, 1'b0);
    reset_in = 1'b0;
    #1;
    check("midrst.busy", 32'(busy_out), 32'h0);
    check("midrst.valid", 32'(evt_valid_out), 32'h0);
    reset_in = 1'b1;
    step();

    // one-shot
    evt_ready_in = 1'b1;
    cfg(2'd1, CMD_LOAD_ONESHOT, 16'd3);
    tick_n(2);
    check_evt("os.t2", 1'b0, 2'd0, 1'b0);
    tick_n(1);
    check_evt("os.t3", 1'b1, 2'd1, 1'b0);
    check("os.busy", 32'(busy_out), 32'h0);
    step();
    check_evt("os.after", 1'b0, 2'd0, 1'b0);

    // periodic with overrun under backpressure
    evt_ready_in = 1'b0;
    cfg(2'd2, CMD_LOAD_PERIODIC, 16'd2);
    tick_n(6);
    check_evt("per.held", 1'b1, 2'd2, 1'b0);
    check("per.busy", 32'(busy_out), 32'h4);
    evt_ready_in = 1'b1;
    step();
    check_evt("per.ovr", 1'b1, 2'd2, 1'b1);
    step();
    check_evt("per.drain", 1'b0, 2'd0, 1'b0);
    tick_n(1);
    check_evt("per.t1", 1'b0, 2'd0, 1'b0);
    tick_n(1);
    check_evt("per.t2", 1'b1, 2'd2, 1'b0);
    tick_n(1);
    check_evt("per.t3", 1'b0, 2'd0, 1'b0);
    tick_n(1);
    check_evt("per.t4", 1'b1, 2'd2, 1'b0);
    check("per.busy2", 32'(busy_out), 32'h4);
    cfg(2'd2, CMD_STOP, 16'd0);
    check("per.stop", 32'(busy_out), 32'h0);
    check_evt("per.stopped", 1'b0, 2'd0, 1'b0);

    reset_in = 1'b0;
    #1;
    reset_in = 1'b1;
    step();

    // round-robin across all channels, twice
    evt_ready_in = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) cfg(2'(c), CMD_LOAD_ONESHOT, 16'd1);
      check("rr.busy", 32'(busy_out), 32'hf);
      tick_n(1);
      check_evt("rr.e0", 1'b1, 2'd0, 1'b0);
      evt_ready_in = 1'b1;
      for (int e = 1; e < 4; e++) begin
        step();
        check_evt("rr.en", 1'b1, 2'(e), 1'b0);
      end
      step();
      check_evt("rr.end", 1'b0, 2'd0, 1'b0);
    end

    // STOP colliding with the expiring tick, then LOAD with N=0
    cfg(2'd3, CMD_LOAD_ONESHOT, 16'd2);
    tick_n(1);
    tick_in = 1'b1;
    cfg(2'd3, CMD_STOP, 16'd0);
    tick_in = 1'b0;
    check_evt("col.none", 1'b0, 2'd0, 1'b0);
    check("col.busy", 32'(busy_out), 32'h0);
    step();
    check_evt("col.none2", 1'b0, 2'd0, 1'b0);
    cfg(2'd3, CMD_LOAD_ONESHOT, 16'd0);
    check("n0.busy", 32'(busy_out), 32'h8);
    tick_n(1);
    check_evt("n0.evt", 1'b1, 2'd3, 1'b0);
    check("n0.idle", 32'(busy_out), 32'h0);
    step();

    // held event stays put under backpressure, even across a LOAD of its channel
    evt_ready_in = 1'b0;
    cfg(2'd1, CMD_LOAD_ONESHOT, 16'd1);
    tick_n(1);
    cfg(2'd0, CMD_LOAD_ONESHOT, 16'd1);
    tick_n(1);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) cfg(2'd1, CMD_LOAD_ONESHOT, 16'd7);
      else step();
      check_evt("bp.hold", 1'b1, 2'd1, 1'b0);
    end
    check("bp.busy", 32'(busy_out), 32'h2);
    evt_ready_in = 1'b1;
    step();
    check_evt("bp.next", 1'b1, 2'd0, 1'b0);
    step();
    check_evt("bp.drain", 1'b0, 2'd0, 1'b0);

`ifdef TIMER_SCHED_READBACK_EN
    cfg(2'd2, CMD_LOAD_ONESHOT, 16'd10);
    tick_n(4);
    rd_chan_in = 2'd2;
    step();
    check("rd.ch2", 32'(rd_count_out), 32'd6);
    rd_chan_in = 2'd3;
    step();
    check("rd.idle", 32'(rd_count_out), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
